// File: rtl/mag_est_pkg.sv
// mag_est_pkg
// Shared definitions for the streaming magnitude estimator:
//   - mag_mode_e   : alpha-max/beta-min approximation select
//   - bin_width()  : number of bits needed to index N bins
//   - shift constants used by each approximation mode
package mag_est_pkg;

    typedef enum logic [1:0] {
        MODE_HALF    = 2'd0,   // big + small/2
        MODE_QUARTER = 2'd1,   // big + small/4
        MODE_FINE    = 2'd2,   // 15/16 big + 15/32 small
        MODE_MAX     = 2'd3    // big only (peak / debug)
    } mag_mode_e;

    // MODE_HALF: beta = 1/2
    localparam int HALF_SMALL_SHIFT    = 1;
    // MODE_QUARTER: beta = 1/4
    localparam int QUARTER_SMALL_SHIFT = 2;
    // MODE_FINE: alpha = 1 - 1/16, beta = 1/2 - 1/32
    localparam int FINE_BIG_SHIFT      = 4;
    localparam int FINE_SMALL_SHIFT_HI = 1;
    localparam int FINE_SMALL_SHIFT_LO = 5;

    function automatic int bin_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mag_est_stream_if.sv
// mag_est_stream_if
// Bundles the input (bin) and output (magnitude) valid/ready streams of
// mag_est_stream.
//   slave  : the estimator's view (consumes bins, produces magnitudes)
//   master : the surrounding system's view (produces bins, consumes magnitudes)
// Signals:
//   in_valid/in_ready/in_sof/in_real/in_imag : bin input stream
//   out_valid/out_ready/out_mag/out_bin/out_last : magnitude output stream
interface mag_est_stream_if
    import mag_est_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int N     = 256
);
    localparam int BIN_W = bin_width(N);

    logic               in_valid;
    logic               in_ready;
    logic               in_sof;
    logic [WIDTH:0]     in_real;
    logic [WIDTH:0]     in_imag;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH+1:0]   out_mag;
    logic [BIN_W-1:0]   out_bin;
    logic               out_last;

    modport slave (
        input  in_valid, in_sof, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_mag, out_bin, out_last
    );

    modport master (
        output in_valid, in_sof, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_mag, out_bin, out_last
    );

endinterface

// File: rtl/mag_est_core.sv
// mag_est_core
// Purely combinational alpha-max/beta-min shift-add.
// Ports:
//   big_mag   in  WIDTH+1  larger absolute component
//   small_mag in  WIDTH+1  smaller absolute component
//   mode      in  mag_mode_e approximation select
//   mag       out WIDTH+2  unsigned magnitude estimate
// Every shifted term is truncated on its own before being combined; the
// WIDTH+2 result width holds the worst case (big + big/2) without overflow.
module mag_est_core
    import mag_est_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH:0]   big_mag,
    input  logic [WIDTH:0]   small_mag,
    input  mag_mode_e        mode,
    output logic [WIDTH+1:0] mag
);
    localparam int MW = WIDTH + 2;

    logic [MW-1:0] big_w;
    logic [MW-1:0] small_w;

    assign big_w   = MW'(big_mag);
    assign small_w = MW'(small_mag);

    always_comb begin
        mag = big_w;
        case (mode)
            MODE_HALF:    mag = big_w + (small_w >> HALF_SMALL_SHIFT);
            MODE_QUARTER: mag = big_w + (small_w >> QUARTER_SMALL_SHIFT);
            // Both differences are non-negative since x>>k <= x.
            MODE_FINE:    mag = (big_w - (big_w >> FINE_BIG_SHIFT))
                              + ((small_w >> FINE_SMALL_SHIFT_HI) - (small_w >> FINE_SMALL_SHIFT_LO));
            MODE_MAX:     mag = big_w;
            default:      mag = big_w;
        endcase
    end

endmodule

// File: rtl/mag_est_stream.sv
// mag_est_stream
// Time-multiplexed complex magnitude estimator: one FFT bin per handshake,
// three register stages (abs / compare-select / shift-add), bin index and
// frame-boundary tracking, valid/ready flow control on both sides.
// Ports:
//   clk        in  sole clock
//   rst        in  synchronous active-high reset
//   mode       in  approximation select, sampled when bin 0 is accepted
//   bus        slave modport of mag_est_stream_if (input/output streams)
//   frame_err  out sticky frame-sync violation flag, cleared only by rst
module mag_est_stream
    import mag_est_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int N     = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    mag_est_stream_if.slave       bus,
    output logic                  frame_err
);
    localparam int BIN_W = bin_width(N);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N - 1);

    // ------------------------------------------------------------------
    // Handshake and per-stage load enables
    // ------------------------------------------------------------------
    logic en;
    logic accept;
    logic ld1, ld2, ld3;

    logic                 s1_valid;
    logic [WIDTH:0]       s1_abs_re;
    logic [WIDTH:0]       s1_abs_im;
    logic [BIN_W-1:0]     s1_bin;
    mag_mode_e            s1_mode;

    logic                 s2_valid;
    logic [WIDTH:0]       s2_big;
    logic [WIDTH:0]       s2_small;
    logic [BIN_W-1:0]     s2_bin;
    mag_mode_e            s2_mode;

    logic                 out_valid_reg;
    logic [WIDTH+1:0]     out_mag_reg;
    logic [BIN_W-1:0]     out_bin_reg;
    logic                 out_last_reg;

    assign en            = !out_valid_reg || bus.out_ready;
    assign bus.in_ready  = en && !rst;
    assign accept        = bus.in_valid && bus.in_ready;

    // An empty stage always loads so bubbles are squeezed out behind a stall.
    assign ld3 = en;
    assign ld2 = ld3 || !s2_valid;
    assign ld1 = ld2 || !s1_valid;

    // ------------------------------------------------------------------
    // Bin counter, frame check and mode latch
    // ------------------------------------------------------------------
    logic [BIN_W-1:0] cnt_reg, cnt_next;
    logic             first_reg, first_next;
    logic             err_reg, err_next;
    mag_mode_e        mode_reg, mode_next;
    logic [BIN_W-1:0] tag;
    mag_mode_e        bin_mode;

    always_comb begin
        cnt_next   = cnt_reg;
        first_next = first_reg;
        err_next   = err_reg;
        mode_next  = mode_reg;
        // sof forces bin 0 regardless of where the counter is.
        tag        = bus.in_sof ? '0 : cnt_reg;
        // Bin 0 uses the mode presented with it; later bins use the latch.
        bin_mode   = (tag == '0) ? mag_mode_e'(mode) : mode_reg;
        if (accept) begin
            cnt_next   = tag + BIN_W'(1);
            first_next = 1'b0;
            if (tag == '0) begin
                mode_next = mag_mode_e'(mode);
            end
            // Early sof: frame restarted before the counter wrapped.
            if (bus.in_sof && (cnt_reg != '0)) begin
                err_next = 1'b1;
            end
            // Missing sof at a frame boundary (the very first frame is exempt).
            if (!bus.in_sof && (cnt_reg == '0) && !first_reg) begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            first_reg <= 1'b1;
            err_reg   <= 1'b0;
            mode_reg  <= MODE_HALF;
        end else begin
            cnt_reg   <= cnt_next;
            first_reg <= first_next;
            err_reg   <= err_next;
            mode_reg  <= mode_next;
        end
    end

    assign frame_err = err_reg;

    // ------------------------------------------------------------------
    // S1: absolute values, bin tag, frame mode
    // ------------------------------------------------------------------
    logic [WIDTH:0] comp_raw [2];
    logic [WIDTH:0] comp_abs [2];

    assign comp_raw[0] = bus.in_real;
    assign comp_raw[1] = bus.in_imag;

    // -2^WIDTH negates to 2^WIDTH, which is representable as unsigned WIDTH+1.
    for (genvar gi = 0; gi < 2; gi++) begin : g_abs
        assign comp_abs[gi] = comp_raw[gi][WIDTH] ? (~comp_raw[gi] + (WIDTH+1)'(1))
                                                  : comp_raw[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_abs_re <= '0;
            s1_abs_im <= '0;
            s1_bin    <= '0;
            s1_mode   <= MODE_HALF;
        end else if (ld1) begin
            s1_valid <= accept;
            if (accept) begin
                s1_abs_re <= comp_abs[0];
                s1_abs_im <= comp_abs[1];
                s1_bin    <= tag;
                s1_mode   <= bin_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: compare and big/small select (tie goes to the real part)
    // ------------------------------------------------------------------
    logic re_ge_im;
    assign re_ge_im = (s1_abs_re >= s1_abs_im);

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_big   <= '0;
            s2_small <= '0;
            s2_bin   <= '0;
            s2_mode  <= MODE_HALF;
        end else if (ld2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_big   <= re_ge_im ? s1_abs_re : s1_abs_im;
                s2_small <= re_ge_im ? s1_abs_im : s1_abs_re;
                s2_bin   <= s1_bin;
                s2_mode  <= s1_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: shift-add and output registers
    // ------------------------------------------------------------------
    logic [WIDTH+1:0] core_mag;

    mag_est_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .big_mag   (s2_big),
        .small_mag (s2_small),
        .mode      (s2_mode),
        .mag       (core_mag)
    );

    // Payload only changes when a valid result moves in, so it holds while
    // stalled and stays at its last value during idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_mag_reg   <= '0;
            out_bin_reg   <= '0;
            out_last_reg  <= 1'b0;
        end else if (ld3) begin
            out_valid_reg <= s2_valid;
            if (s2_valid) begin
                out_mag_reg  <= core_mag;
                out_bin_reg  <= s2_bin;
                out_last_reg <= (s2_bin == LAST_BIN);
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_mag   = out_mag_reg;
    assign bus.out_bin   = out_bin_reg;
    assign bus.out_last  = out_last_reg;

endmodule

// File: tb/tb_mag_est_stream.sv
// tb_mag_est_stream
// Self-checking bench for mag_est_stream (WIDTH=12, N=8): table of known
// vectors, hand-written frame/stall/reset sequences, and a randomized
// stream checked against a behavioural scoreboard model.
module tb_mag_est_stream;
    import mag_est_pkg::*;

    localparam int WIDTH = 12;
    localparam int N     = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode_sig;
    logic       frame_err;

    always #5 clk = ~clk;

    mag_est_stream_if #(.WIDTH(WIDTH), .N(N)) bus ();

    mag_est_stream #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode_sig),
        .bus       (bus),
        .frame_err (frame_err)
    );

    typedef struct {
        int mag;
        int bin;
        bit last;
    } exp_t;

    typedef struct {
        int re;
        int im;
        int md;
        int exp_mag;
    } vec_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // behavioural model state
    int m_cnt;
    bit m_first;
    int m_mode;
    bit m_err;

    // stall tracking
    bit prev_stall;
    int prev_mag, prev_bin;
    bit prev_last;

    // drive values
    bit d_valid, d_sof, d_ready;
    int d_re, d_im, d_mode;

    int acc_count;
    int xfer_count;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Magnitude estimate straight from the approximation formulas.
    function automatic int ref_mag(input int re, input int im, input int md);
        int a, b, big_v, sml_v;
        a = iabs(re);
        b = iabs(im);
        big_v = (a >= b) ? a : b;
        sml_v = (a >= b) ? b : a;
        case (md)
            0:       return big_v + sml_v / 2;
            1:       return big_v + sml_v / 4;
            2:       return (big_v - big_v / 16) + (sml_v / 2 - sml_v / 32);
            default: return big_v;
        endcase
    endfunction

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic step();
        bit   exp_ready;
        int   tag;
        exp_t e;
        bus.in_valid  = d_valid;
        bus.in_sof    = d_sof;
        bus.in_real   = (WIDTH+1)'(d_re);
        bus.in_imag   = (WIDTH+1)'(d_im);
        bus.out_ready = d_ready;
        mode_sig      = 2'(d_mode);
        #1;
        chk("frame_err", frame_err, m_err);
        exp_ready = !bus.out_valid || d_ready;
        chk("in_ready", bus.in_ready, exp_ready);
        if (prev_stall) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_mag", bus.out_mag, prev_mag);
            chk("stall_bin", bus.out_bin, prev_bin);
            chk("stall_last", bus.out_last, prev_last);
        end
        if (bus.out_valid && d_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                xfer_count++;
                $display("xfer bin=%0d mag=%0d last=%0d (expected bin=%0d mag=%0d last=%0d)",
                         bus.out_bin, bus.out_mag, bus.out_last, e.bin, e.mag, e.last);
                chk("out_mag", bus.out_mag, e.mag);
                chk("out_bin", bus.out_bin, e.bin);
                chk("out_last", bus.out_last, e.last);
            end
        end
        prev_stall = bus.out_valid && !d_ready;
        prev_mag   = int'(bus.out_mag);
        prev_bin   = int'(bus.out_bin);
        prev_last  = bus.out_last;
        if (d_valid && exp_ready) begin
            acc_count++;
            tag = d_sof ? 0 : m_cnt;
            if (d_sof && m_cnt != 0) m_err = 1'b1;
            if (!d_sof && m_cnt == 0 && !m_first) m_err = 1'b1;
            m_first = 1'b0;
            if (tag == 0) m_mode = d_mode;
            e.mag  = ref_mag(d_re, d_im, m_mode);
            e.bin  = tag;
            e.last = (tag == N - 1);
            exp_q.push_back(e);
            m_cnt = (tag + 1) % N;
        end
        @(negedge clk);
    endtask

    // Reset for one cycle; called at a negedge, returns at a negedge.
    task automatic do_reset();
        rst = 1'b1;
        d_valid = 1'b0; d_sof = 1'b0; d_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_mag", bus.out_mag, 0);
        chk("rst_out_bin", bus.out_bin, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_frame_err", frame_err, 0);
        exp_q.delete();
        m_cnt = 0; m_first = 1'b1; m_mode = 0; m_err = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        d_valid = 1'b0; d_sof = 1'b0; d_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[11];
        int   lat;
        int   pat[4];
        int   gaps;
        bit   seen;

        rst = 1'b1;
        d_valid = 0; d_sof = 0; d_ready = 0; d_re = 0; d_im = 0; d_mode = 0;
        acc_count = 0; xfer_count = 0;
        bus.in_valid = 0; bus.in_sof = 0; bus.in_real = '0; bus.in_imag = '0;
        bus.out_ready = 0; mode_sig = 2'd0;
        @(negedge clk);

        // ---------------- table-driven vectors, latency 3 ----------------
        tbl[0]  = '{300, -400, 0, 550};
        tbl[1]  = '{300, -400, 1, 475};
        tbl[2]  = '{300, -400, 2, 516};
        tbl[3]  = '{300, -400, 3, 400};
        tbl[4]  = '{-4096, -4096, 0, 6144};
        tbl[5]  = '{0, 0, 0, 0};
        tbl[6]  = '{-4096, 4095, 2, 5760};
        tbl[7]  = '{4095, -4096, 1, 5119};
        tbl[8]  = '{-1, 1, 0, 1};
        tbl[9]  = '{-4096, -4096, 3, 4096};
        tbl[10] = '{-4096, -4096, 2, 5760};
        for (int i = 0; i < 11; i++) begin
            do_reset();
            d_valid = 1; d_sof = 1; d_ready = 1;
            d_re = tbl[i].re; d_im = tbl[i].im; d_mode = tbl[i].md;
            step();
            d_valid = 0; d_sof = 0;
            lat = 1;
            while (!bus.out_valid && lat < 10) begin
                step();
                lat++;
            end
            chk("latency", lat, 3);
            chk("tbl_mag", bus.out_mag, tbl[i].exp_mag);
            chk("tbl_bin", bus.out_bin, 0);
            step();
        end

        // ------- 4 frames, mode per frame, ready pattern 1-0-0-1 -------
        do_reset();
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        acc_count = 0; xfer_count = 0; gaps = 0; seen = 0;
        d_re = 300; d_im = -400;
        for (int c = 0; c < 400 && xfer_count < 4 * N; c++) begin
            d_valid = (acc_count < 4 * N);
            d_sof   = (acc_count % N == 0);
            // bin 0 carries the frame's mode; a different mode mid-frame must be ignored
            d_mode  = (acc_count % N == 0) ? (acc_count / N) % 4 : ((acc_count / N) + 1) % 4;
            d_ready = pat[c % 4];
            if (bus.out_valid) seen = 1;
            else if (seen && exp_q.size() > 0) gaps++;
            step();
        end
        chk("stream_xfers", xfer_count, 4 * N);
        chk("throughput_gaps", gaps, 0);
        drain();

        // ---------------- early sof at bin 5 ----------------
        do_reset();
        d_ready = 1; d_re = 100; d_im = 50; d_mode = 1;
        for (int b = 0; b < 5; b++) begin
            d_valid = 1; d_sof = (b == 0);
            step();
        end
        chk("pre_err_clear", frame_err, 0);
        d_valid = 1; d_sof = 1; d_re = -700; d_im = 20;
        step();
        drain();
        chk("early_sof_err", frame_err, 1);
        for (int k = 0; k < 3; k++) step();
        chk("early_sof_sticky", frame_err, 1);

        // ---------------- missing sof at wrap ----------------
        do_reset();
        d_ready = 1; d_mode = 2;
        for (int b = 0; b < N + 1; b++) begin
            d_valid = 1; d_sof = (b == 0);
            d_re = b * 37 - 150; d_im = 200 - b * 11;
            step();
        end
        drain();
        chk("missing_sof_err", frame_err, 1);

        // ---------------- mid-stream reset ----------------
        do_reset();
        d_ready = 0; d_mode = 0;
        for (int b = 0; b < 3; b++) begin
            d_valid = 1; d_sof = (b == 0); d_re = 1000 + b; d_im = -3;
            step();
        end
        chk("inflight_valid", bus.out_valid, 1);
        do_reset();
        d_ready = 1;
        for (int k = 0; k < 5; k++) step();
        chk("post_rst_idle", bus.out_valid, 0);
        // first frame after reset: no sof needed, mode change at bin 3 deferred
        for (int b = 0; b < 2 * N; b++) begin
            d_valid = 1;
            d_sof   = (b == N);
            d_mode  = (b < 3) ? 1 : 3;
            d_re    = 500 - b * 60; d_im = b * 45 - 300;
            step();
        end
        drain();
        chk("post_rst_no_err", frame_err, 0);

        // ---------------- randomized stream ----------------
        do_reset();
        for (int c = 0; c < 400; c++) begin
            d_valid = ($urandom_range(0, 3) != 0);
            d_ready = ($urandom_range(0, 2) != 0);
            d_sof   = (m_cnt == 0);
            d_mode  = $urandom_range(0, 3);
            d_re    = $urandom_range(0, 8191) - 4096;
            d_im    = $urandom_range(0, 8191) - 4096;
            if ($urandom_range(0, 7) == 0) d_re = -4096;
            if ($urandom_range(0, 7) == 0) d_im = -4096;
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
